dtw_core_ctrl: RTL

Second-generation, parametrised controller for the DTW acceleration core. It sits between the AXI-Stream input/output ports and the reference memory and DTW datapath, which are exposed as ports so the controller is verified standalone. Compared with the first generation it adds:
- a valid/ready stream handshake in place of raw FIFO strobes
- runtime query length
- reference clear/reload and abort
- threshold hit filtering
- a 4-word result record with status
- query/hit counters

---
 rtl/dtw_core_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dtw_core_ctrl.sv
// DTW acceleration core controller: stream handshake, reference load/clear, query sequencing,
// threshold hit filtering and 4-word result records.
`timescale 1ns / 1ps
module dtw_core_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REF_AW = 15,
    parameter int unsigned QLEN_W = 10,
    parameter int unsigned FILTER = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op_mode,
    input  logic              abort,
    input  logic [REF_AW:0]   ref_len,
    input  logic [QLEN_W-1:0] qry_len,
    input  logic [WIDTH-1:0]  threshold,
    output logic              busy,
    output logic              ref_valid,
    output logic              err,
    output logic [31:0]       qry_count,
    output logic [31:0]       hit_count,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              ref_wr_en,
    output logic [REF_AW-1:0] ref_wr_addr,
    output logic [WIDTH-1:0]  ref_wr_data,
    output logic              dp_rst,
    output logic              dp_start,
    output logic              dp_sample_valid,
    output logic [WIDTH-1:0]  dp_sample,
    input  logic              dp_done,
    input  logic [WIDTH-1:0]  dp_minval,
    input  logic [DATA_W-1:0] dp_position,
    output logic              sink_valid,
    input  logic              sink_ready,
    output logic [DATA_W-1:0] sink_data,
    output logic              sink_last
);

    localparam int unsigned CntW = (REF_AW + 1 > QLEN_W) ? REF_AW + 1 : QLEN_W;

    typedef enum logic [2:0] {StIdle, StLoad, StQId, StQStream, StQWait, StEmit} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]   cnt_q;
    logic [REF_AW:0]   ref_len_q;
    logic [QLEN_W-1:0] qry_len_q;
    logic [WIDTH-1:0]  threshold_q;
    logic [DATA_W-1:0] qid_q;
    logic [DATA_W-1:0] pos_q;
    logic [WIDTH-1:0]  minval_q;
    logic              hit_q;
    logic [1:0]        word_q;
    logic              ref_valid_q, err_q;
    logic [31:0]       qry_count_q, hit_count_q;
    logic              ref_wr_en_q;
    logic [REF_AW-1:0] ref_wr_addr_q;
    logic [WIDTH-1:0]  ref_wr_data_q;
    logic              dp_start_q, dp_sample_valid_q;
    logic [WIDTH-1:0]  dp_sample_q;

    logic            accept, load_ok, qry_ok, last_ref, last_qry, emit_skip, dp_hit;
    logic [CntW-1:0] cnt_inc;

    // Lengths up to exactly 2^REF_AW are legal, so only the top bit alone may be set.
    assign load_ok   = (ref_len != '0) && (!ref_len[REF_AW] || (ref_len[REF_AW-1:0] == '0));
    assign qry_ok    = ref_valid_q && (qry_len != '0);
    assign accept    = src_valid && src_ready;
    assign cnt_inc   = cnt_q + 1'b1;
    assign last_ref  = (cnt_inc == CntW'(ref_len_q));
    assign last_qry  = (cnt_inc == CntW'(qry_len_q));
    assign emit_skip = (FILTER != 0) && !hit_q;
    assign dp_hit    = (dp_minval <= threshold_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (op_mode == 2'd1 && load_ok)     state_d = StLoad;
                    else if (op_mode == 2'd0 && qry_ok) state_d = StQId;
                end
            end
            StLoad:    if (abort || (accept && last_ref)) state_d = StIdle;
            StQId:     if (abort) state_d = StIdle; else if (accept) state_d = StQStream;
            StQStream: if (abort) state_d = StIdle; else if (accept && last_qry) state_d = StQWait;
            StQWait:   if (abort) state_d = StIdle; else if (dp_done) state_d = StEmit;
            StEmit:    if (emit_skip || (sink_ready && word_q == 2'd3)) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state_q != StIdle);
        src_ready  = (state_q == StLoad) || (state_q == StQId) || (state_q == StQStream);
        dp_rst     = rst || (state_q == StIdle);
        sink_valid = (state_q == StEmit) && !emit_skip;
        sink_last  = sink_valid && (word_q == 2'd3);
        sink_data  = '0;
        if (state_q == StEmit) begin
            unique case (word_q)
                2'd0: sink_data = qid_q;
                2'd1: sink_data = pos_q;
                2'd2: sink_data = DATA_W'(minval_q);
                2'd3: sink_data = DATA_W'({ref_len_q, hit_q});
                default: sink_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q             <= '0;
            ref_len_q         <= '0;
            qry_len_q         <= '0;
            threshold_q       <= '0;
            qid_q             <= '0;
            pos_q             <= '0;
            minval_q          <= '0;
            hit_q             <= 1'b0;
            word_q            <= '0;
            ref_valid_q       <= 1'b0;
            err_q             <= 1'b0;
            qry_count_q       <= '0;
            hit_count_q       <= '0;
            ref_wr_en_q       <= 1'b0;
            ref_wr_addr_q     <= '0;
            ref_wr_data_q     <= '0;
            dp_start_q        <= 1'b0;
            dp_sample_valid_q <= 1'b0;
            dp_sample_q       <= '0;
        end else begin
            ref_wr_en_q       <= 1'b0;
            dp_start_q        <= 1'b0;
            dp_sample_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        case (op_mode)
                            2'd0: begin
                                if (qry_ok) begin
                                    qry_len_q   <= qry_len;
                                    threshold_q <= threshold;
                                    cnt_q       <= '0;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            2'd1: begin
                                if (load_ok) begin
                                    ref_len_q   <= ref_len;
                                    ref_valid_q <= 1'b0;
                                    cnt_q       <= '0;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            2'd2:    ref_valid_q <= 1'b0;
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                StLoad: begin
                    if (!abort && accept) begin
                        ref_wr_en_q   <= 1'b1;
                        ref_wr_addr_q <= cnt_q[REF_AW-1:0];
                        ref_wr_data_q <= src_data[WIDTH-1:0];
                        cnt_q         <= cnt_inc;
                        if (last_ref) ref_valid_q <= 1'b1;
                    end
                end
                StQId: begin
                    if (!abort && accept) begin
                        qid_q      <= src_data;
                        dp_start_q <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                StQStream: begin
                    if (!abort && accept) begin
                        dp_sample_q       <= src_data[WIDTH-1:0];
                        dp_sample_valid_q <= 1'b1;
                        cnt_q             <= cnt_inc;
                    end
                end
                StQWait: begin
                    if (!abort && dp_done) begin
                        minval_q    <= dp_minval;
                        pos_q       <= dp_position;
                        hit_q       <= dp_hit;
                        word_q      <= '0;
                        qry_count_q <= qry_count_q + 32'd1;
                        if (dp_hit) hit_count_q <= hit_count_q + 32'd1;
                    end
                end
                StEmit: if (sink_valid && sink_ready) word_q <= word_q + 2'd1;
                default: ;
            endcase
        end
    end

    assign ref_valid       = ref_valid_q;
    assign err             = err_q;
    assign qry_count       = qry_count_q;
    assign hit_count       = hit_count_q;
    assign ref_wr_en       = ref_wr_en_q;
    assign ref_wr_addr     = ref_wr_addr_q;
    assign ref_wr_data     = ref_wr_data_q;
    assign dp_start        = dp_start_q;
    assign dp_sample_valid = dp_sample_valid_q;
    assign dp_sample       = dp_sample_q;

endmodule
